// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg: shared definitions for the MEM-stage load/store unit.
//   - LS_* opcodes (4-bit) carried on lsop_i
//   - FSM state encoding and access-size classification
//   - lane_sel():     byte-enable pattern for a given size and lane offset
//   - load_extract(): picks the addressed byte/half out of a bus word and
//                     sign- or zero-extends it according to the opcode
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [3:0] LS_NONE = 4'd0;
  localparam logic [3:0] LS_LB   = 4'd1;
  localparam logic [3:0] LS_LBU  = 4'd2;
  localparam logic [3:0] LS_LH   = 4'd3;
  localparam logic [3:0] LS_LHU  = 4'd4;
  localparam logic [3:0] LS_LW   = 4'd5;
  localparam logic [3:0] LS_LL   = 4'd6;
  localparam logic [3:0] LS_SB   = 4'd7;
  localparam logic [3:0] LS_SH   = 4'd8;
  localparam logic [3:0] LS_SW   = 4'd9;
  localparam logic [3:0] LS_SC   = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } lsu_size_e;

  // Unknown opcodes classify as SZ_NONE and therefore behave like LS_NONE.
  function automatic lsu_size_e op_size(input logic [3:0] op);
    case (op)
      LS_LB, LS_LBU, LS_SB:               return SZ_BYTE;
      LS_LH, LS_LHU, LS_SH:               return SZ_HALF;
      LS_LW, LS_LL, LS_SW, LS_SC:         return SZ_WORD;
      default:                            return SZ_NONE;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [3:0] op);
    return op inside {LS_LB, LS_LBU, LS_LH, LS_LHU, LS_LW, LS_LL};
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return op inside {LS_SB, LS_SH, LS_SW, LS_SC};
  endfunction

  // b and h are the already endian-adjusted byte and half lane indices.
  function automatic logic [3:0] lane_sel(input lsu_size_e sz,
                                          input logic [1:0] b,
                                          input logic h);
    case (sz)
      SZ_BYTE: return 4'b0001 << b;
      SZ_HALF: return 4'b0011 << {h, 1'b0};
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [3:0]  op,
                                               input logic [31:0] rdata,
                                               input logic [1:0]  b,
                                               input logic        h);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v = 8'(rdata >> {b, 3'b000});
    half_v = 16'(rdata >> {h, 4'b0000});
    case (op)
      LS_LB:   return {{24{byte_v[7]}}, byte_v};
      LS_LBU:  return {24'd0, byte_v};
      LS_LH:   return {{16{half_v[15]}}, half_v};
      LS_LHU:  return {16'd0, half_v};
      default: return rdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// -----------------------------------------------------------------------------
// mem_lsu_if: request/acknowledge data bus between the MEM stage and memory.
//   master (LSU side):    drives bus_req_o, bus_we_o, bus_addr_o, bus_sel_o,
//                         bus_wdata_o; samples bus_rdata_i, bus_ack_i
//   slave (memory side):  the mirror image
// bus_ack_i completes a transfer in the cycle it is high while bus_req_o is high.
// -----------------------------------------------------------------------------
interface mem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [3:0]        bus_sel_o;
  logic [31:0]       bus_wdata_o;
  logic [31:0]       bus_rdata_i;
  logic              bus_ack_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
    input  bus_rdata_i, bus_ack_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
    output bus_rdata_i, bus_ack_i
  );
endinterface

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align: purely combinational lane logic for the load/store unit.
//   op, addr_lo  : opcode and low two address bits of the access
//   st_data      : store data, replicated onto all lanes in wdata
//   rdata        : raw bus read word, formatted into ld_data
//   is_mem/is_load/is_store : opcode classification
//   misalign     : half access on odd address, word access not 4-aligned
//   sel          : byte-lane enables (BIG_ENDIAN mirrors the lane index)
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic        is_mem,
  output logic        is_load,
  output logic        is_store,
  output logic        misalign,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  localparam logic [1:0] LANE_FLIP = (BIG_ENDIAN != 0) ? 2'b11 : 2'b00;

  lsu_size_e  sz;
  logic [1:0] b;
  logic       h;

  assign sz       = op_size(op);
  assign b        = addr_lo ^ LANE_FLIP;
  assign h        = addr_lo[1] ^ LANE_FLIP[1];
  assign is_mem   = (sz != SZ_NONE);
  assign is_load  = op_is_load(op);
  assign is_store = op_is_store(op);
  assign misalign = ((sz == SZ_HALF) && addr_lo[0]) ||
                    ((sz == SZ_WORD) && (addr_lo != 2'b00));
  assign sel      = lane_sel(sz, b, h);
  assign ld_data  = load_extract(op, rdata, b, h);

  // Narrow stores are replicated so the slave can take the data from any lane.
  always_comb begin
    case (sz)
      SZ_BYTE: wdata = {4{st_data[7:0]}};
      SZ_HALF: wdata = {2{st_data[15:0]}};
      default: wdata = st_data;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu: MEM pipeline stage with load/store unit.
//   clk, rst            : clock, synchronous active-high reset
//   valid_i, lsop_i     : live instruction and its load/store opcode
//   w_reg_addr_i, we_i, w_data_i : write-back triple (store data for stores)
//   mem_addr_i          : effective address
//   flush_i             : pipeline flush (kills IDLE op, marks WAIT op dead)
//   w_reg_addr_o, we_o, w_data_o : write-back triple to MEM/WB
//   stall_req_o         : hold the pipeline while a transfer is outstanding
//   misalign_o          : address-error exception request
//   bus_err_o           : one-cycle pulse when the bus never acknowledged
//   bus                 : request/acknowledge data bus (master side)
// ALU ops pass straight through. Memory ops are issued from the live inputs;
// if not acknowledged in that cycle the op is captured and replayed from the
// captured copy in WAIT until ack or timeout.
// -----------------------------------------------------------------------------
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int BIG_ENDIAN  = 0,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [3:0]            lsop_i,
  input  logic [REG_ADDR_W-1:0] w_reg_addr_i,
  input  logic                  we_i,
  input  logic [31:0]           w_data_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic                  flush_i,
  output logic [REG_ADDR_W-1:0] w_reg_addr_o,
  output logic                  we_o,
  output logic [31:0]           w_data_o,
  output logic                  stall_req_o,
  output logic                  misalign_o,
  output logic                  bus_err_o,
  mem_lsu_if.master             bus
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  lsu_state_e            state;
  logic                  llbit;
  logic [TW-1:0]         tcnt;
  logic                  flushed;

  logic [3:0]            lat_op;
  logic [ADDR_W-1:0]     lat_addr;
  logic [31:0]           lat_data;
  logic [REG_ADDR_W-1:0] lat_reg;

  logic                  in_idle;
  logic [3:0]            cur_op;
  logic [ADDR_W-1:0]     cur_addr;
  logic [31:0]           cur_data;
  logic [REG_ADDR_W-1:0] cur_reg;

  logic                  is_mem, is_load, is_store, misalign;
  logic [3:0]            sel;
  logic [31:0]           wdata, ld_data;

  logic                  sc_fail, timeout, suppress;
  logic                  complete, go_wait, ll_set, ll_clr;

  assign in_idle  = (state == ST_IDLE);

  // In IDLE the op comes from the live inputs (a flush kills it outright);
  // in WAIT the stage replays the captured copy since the pipeline is frozen.
  assign cur_op   = in_idle ? ((valid_i && !flush_i) ? lsop_i : LS_NONE) : lat_op;
  assign cur_addr = in_idle ? mem_addr_i   : lat_addr;
  assign cur_data = in_idle ? w_data_i     : lat_data;
  assign cur_reg  = in_idle ? w_reg_addr_i : lat_reg;

  // SC only consults the link bit at issue; once in WAIT it must finish.
  assign sc_fail  = in_idle && (cur_op == LS_SC) && !llbit;
  assign timeout  = !in_idle && (tcnt == TW'(ACK_TIMEOUT));
  assign suppress = !in_idle && (flushed || flush_i);

  lsu_align #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_align (
    .op       (cur_op),
    .addr_lo  (cur_addr[1:0]),
    .st_data  (cur_data),
    .rdata    (bus.bus_rdata_i),
    .is_mem   (is_mem),
    .is_load  (is_load),
    .is_store (is_store),
    .misalign (misalign),
    .sel      (sel),
    .wdata    (wdata),
    .ld_data  (ld_data)
  );

  // NOTE: every signal assigned here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_reg_addr_o    = '0;
    we_o            = 1'b0;
    w_data_o        = '0;
    stall_req_o     = 1'b0;
    misalign_o      = 1'b0;
    bus_err_o       = 1'b0;
    bus.bus_req_o   = 1'b0;
    bus.bus_we_o    = 1'b0;
    bus.bus_addr_o  = '0;
    bus.bus_sel_o   = '0;
    bus.bus_wdata_o = '0;
    complete        = 1'b0;
    go_wait         = 1'b0;
    ll_set          = 1'b0;
    ll_clr          = 1'b0;

    if (!rst) begin
      w_reg_addr_o = cur_reg;
      w_data_o     = cur_data;
      if (!is_mem) begin
        we_o = in_idle && valid_i && !flush_i && we_i;
      end else if (misalign) begin
        misalign_o = 1'b1;
      end else if (sc_fail) begin
        w_data_o = '0;
        we_o     = 1'b1;
      end else begin
        bus.bus_req_o   = 1'b1;
        bus.bus_we_o    = is_store;
        bus.bus_addr_o  = {cur_addr[ADDR_W-1:2], 2'b00};
        bus.bus_sel_o   = sel;
        bus.bus_wdata_o = wdata;
        if (bus.bus_ack_i) begin
          // Ack wins over a same-cycle timeout.
          complete = 1'b1;
          if (is_load)                w_data_o = ld_data;
          else if (cur_op == LS_SC)   w_data_o = 32'd1;
          we_o   = (is_load || (cur_op == LS_SC)) && !suppress;
          ll_set = (cur_op == LS_LL) && !suppress;
          ll_clr = (cur_op == LS_SC);
        end else if (timeout) begin
          complete      = 1'b1;
          bus.bus_req_o = 1'b0;
          bus_err_o     = !suppress;
        end else begin
          stall_req_o = 1'b1;
          go_wait     = in_idle;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      llbit   <= 1'b0;
      tcnt    <= '0;
      flushed <= 1'b0;
    end else begin
      if (flush_i)     llbit <= 1'b0;
      else if (ll_set) llbit <= 1'b1;
      else if (ll_clr) llbit <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (go_wait) begin
            state   <= ST_WAIT;
            tcnt    <= TW'(1);
            flushed <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (complete) begin
            state   <= ST_IDLE;
            tcnt    <= '0;
            flushed <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
            if (flush_i) flushed <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the captured op fields are datapath only; they are read solely in
  // WAIT, which is always entered through a capture, so they need no reset.
  always_ff @(posedge clk) begin
    if (go_wait) begin
      lat_op   <= cur_op;
      lat_addr <= cur_addr;
      lat_data <= cur_data;
      lat_reg  <= cur_reg;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_lsu: self-checking bench for mem_lsu. Two instances run in lockstep
// on the same pipeline inputs: one little-endian, one big-endian. Expected
// values come from a byte-addressed reference model of the access.
// -----------------------------------------------------------------------------
module tb_mem_lsu;
  import lsu_pkg::*;

  localparam int ACK_TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [3:0]  lsop;
  logic [4:0]  w_reg;
  logic        we_in;
  logic [31:0] w_data;
  logic [31:0] mem_addr;
  logic        flush;

  logic [4:0]  w_reg_le, w_reg_be;
  logic        we_le, we_be;
  logic [31:0] wd_le, wd_be;
  logic        stall_le, stall_be, mis_le, mis_be, err_le, err_be;

  int checks = 0;
  int errors = 0;
  bit m_ll   = 1'b0;

  mem_lsu_if #(.ADDR_W(32)) bus_le ();
  mem_lsu_if #(.ADDR_W(32)) bus_be ();

  mem_lsu #(.ADDR_W(32), .REG_ADDR_W(5), .BIG_ENDIAN(0), .ACK_TIMEOUT(ACK_TO)) dut_le (
    .clk(clk), .rst(rst), .valid_i(valid), .lsop_i(lsop), .w_reg_addr_i(w_reg),
    .we_i(we_in), .w_data_i(w_data), .mem_addr_i(mem_addr), .flush_i(flush),
    .w_reg_addr_o(w_reg_le), .we_o(we_le), .w_data_o(wd_le), .stall_req_o(stall_le),
    .misalign_o(mis_le), .bus_err_o(err_le), .bus(bus_le.master)
  );

  mem_lsu #(.ADDR_W(32), .REG_ADDR_W(5), .BIG_ENDIAN(1), .ACK_TIMEOUT(ACK_TO)) dut_be (
    .clk(clk), .rst(rst), .valid_i(valid), .lsop_i(lsop), .w_reg_addr_i(w_reg),
    .we_i(we_in), .w_data_i(w_data), .mem_addr_i(mem_addr), .flush_i(flush),
    .w_reg_addr_o(w_reg_be), .we_o(we_be), .w_data_o(wd_be), .stall_req_o(stall_be),
    .misalign_o(mis_be), .bus_err_o(err_be), .bus(bus_be.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req0, mis0, stall0, bus_we;
    logic [3:0]  sel_le, sel_be;
    logic [31:0] wdata, baddr;
    int          stalls;
    logic [31:0] res_le, res_be;
    logic        we, we_b, stall_ack;
    logic [4:0]  reg_o;
  } obs_t;

  // ---------------- reference model (byte-addressed view) ----------------
  function automatic int op_bytes(input logic [3:0] op);
    if (op inside {LS_LB, LS_LBU, LS_SB}) return 1;
    if (op inside {LS_LH, LS_LHU, LS_SH}) return 2;
    return 4;
  endfunction

  function automatic bit m_is_load(input logic [3:0] op);
    return op inside {LS_LB, LS_LBU, LS_LH, LS_LHU, LS_LW, LS_LL};
  endfunction

  // Memory offset k of the word lives in lane k (LE) or lane 3-k (BE).
  function automatic int lane_of(input int off, input bit be);
    return be ? 3 - off : off;
  endfunction

  function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] a, input bit be);
    logic [3:0] s = '0;
    for (int k = 0; k < op_bytes(op); k++) s[lane_of(int'(a[1:0]) + k, be)] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] rd, input bit be);
    logic [31:0] v = '0;
    logic [7:0]  by;
    int          n = op_bytes(op);
    for (int k = 0; k < n; k++) begin
      by = rd[8*lane_of(int'(a[1:0]) + k, be) +: 8];
      if (be) v = (v << 8) | 32'(by);     // lowest address is most significant
      else    v = v | (32'(by) << (8*k));  // lowest address is least significant
    end
    if (op == LS_LB) v = {{24{v[7]}}, v[7:0]};
    if (op == LS_LH) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
    if (op_bytes(op) == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (op_bytes(op) == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ack(input logic a, input logic [31:0] rd);
    bus_le.bus_ack_i = a; bus_be.bus_ack_i = a;
    bus_le.bus_rdata_i = rd; bus_be.bus_rdata_i = rd;
  endtask

  task automatic idle_inputs;
    valid = 1'b0; lsop = LS_NONE; we_in = 1'b0; flush = 1'b0;
    set_ack(1'b0, 32'd0);
  endtask

  // Issue one memory op; ack arrives lat cycles after issue, flush_i is high
  // in cycle flush_cyc (-1 = never). Returns what was seen on the outputs.
  task automatic do_mem(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rg, input logic [31:0] rd, input int lat,
                        input int flush_cyc, output obs_t o);
    o = '{default: '0};
    valid = 1'b1; lsop = op; mem_addr = a; w_data = d; w_reg = rg; we_in = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      set_ack(c == lat, rd);
      flush = (c == flush_cyc);
      #4;
      if (c == 0) begin
        o.req0 = bus_le.bus_req_o; o.mis0 = mis_le; o.stall0 = stall_le;
        o.bus_we = bus_le.bus_we_o; o.sel_le = bus_le.bus_sel_o; o.sel_be = bus_be.bus_sel_o;
        o.wdata = bus_le.bus_wdata_o; o.baddr = bus_le.bus_addr_o;
      end
      if (c == lat) begin
        o.res_le = wd_le; o.res_be = wd_be; o.we = we_le; o.we_b = we_be;
        o.stall_ack = stall_le; o.reg_o = w_reg_le;
      end else if (stall_le) begin
        o.stalls++;
      end
      tick;
    end
    idle_inputs();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; valid = 1'b1; lsop = LS_LW; mem_addr = 32'h100; w_data = 32'h1234_5678;
    w_reg = 5'd7; we_in = 1'b1; flush = 1'b0; set_ack(1'b1, 32'hFFFF_FFFF);
    tick; tick;
    #4;
    checks++;
    if ({we_le, wd_le, w_reg_le, stall_le, mis_le, err_le} !== '0) begin
      errors++; $display("FAIL reset_wb got we=%b d=%h r=%0d st=%b mis=%b err=%b exp all 0",
                         we_le, wd_le, w_reg_le, stall_le, mis_le, err_le);
    end
    checks++;
    if ({bus_le.bus_req_o, bus_le.bus_we_o, bus_le.bus_addr_o, bus_le.bus_sel_o,
         bus_le.bus_wdata_o} !== '0) begin
      errors++; $display("FAIL reset_bus got req=%b sel=%b exp all 0",
                         bus_le.bus_req_o, bus_le.bus_sel_o);
    end
    tick;
    idle_inputs();
    rst = 1'b0;
    tick;
  endtask

  task automatic test_passthrough;
    logic [31:0] d;
    logic [4:0]  r;
    logic        w, v;
    valid = 1'b1; lsop = LS_NONE; w_reg = 5'd3; we_in = 1'b1; w_data = 32'hDEAD_BEEF;
    mem_addr = 32'h3;
    #4;
    checks++;
    if ({w_reg_le, we_le, wd_le, stall_le, bus_le.bus_req_o} !== {5'd3, 1'b1, 32'hDEAD_BEEF, 2'b00}) begin
      errors++; $display("FAIL alu_pass got r=%0d we=%b d=%h st=%b req=%b exp r=3 we=1 d=deadbeef st=0 req=0",
                         w_reg_le, we_le, wd_le, stall_le, bus_le.bus_req_o);
    end
    tick;
    for (int i = 0; i < 8; i++) begin
      d = $urandom; r = 5'($urandom); w = 1'($urandom); v = 1'($urandom);
      valid = v; lsop = v ? LS_NONE : 4'($urandom_range(1, 10)); w_reg = r; we_in = w; w_data = d;
      mem_addr = $urandom;
      #4;
      checks++;
      if ({w_reg_le, we_le, wd_le, stall_le, bus_le.bus_req_o} !== {r, w & v, d, 2'b00}) begin
        errors++; $display("FAIL alu_rand got r=%0d we=%b d=%h exp r=%0d we=%b d=%h",
                           w_reg_le, we_le, wd_le, r, w & v, d);
      end
      tick;
    end
    idle_inputs();
    tick;
  endtask

  task automatic test_load_wait;
    obs_t o;
    do_mem(LS_LB, 32'h1003, 32'd0, 5'd9, 32'h80FF_1234, 3, -1, o);
    checks++;
    if (o.stalls !== 3 || o.stall0 !== 1'b1 || o.stall_ack !== 1'b0) begin
      errors++; $display("FAIL lb_stall got stalls=%0d ack_stall=%b exp 3 / 0", o.stalls, o.stall_ack);
    end
    checks++;
    if (o.sel_le !== 4'b1000) begin
      errors++; $display("FAIL lb_sel got %b exp 1000", o.sel_le);
    end
    checks++;
    if ({o.we, o.res_le, o.reg_o} !== {1'b1, 32'hFFFF_FF80, 5'd9}) begin
      errors++; $display("FAIL lb_data got we=%b d=%h r=%0d exp we=1 d=ffffff80 r=9", o.we, o.res_le, o.reg_o);
    end
    checks++;
    if (o.res_be !== m_load(LS_LB, 32'h1003, 32'h80FF_1234, 1'b1)) begin
      errors++; $display("FAIL lb_be_data got %h exp %h", o.res_be, m_load(LS_LB, 32'h1003, 32'h80FF_1234, 1'b1));
    end
    do_mem(LS_LBU, 32'h1003, 32'd0, 5'd9, 32'h80FF_1234, 3, -1, o);
    checks++;
    if ({o.we, o.res_le, o.stalls} !== {1'b1, 32'h0000_0080, 32'd3}) begin
      errors++; $display("FAIL lbu_data got we=%b d=%h stalls=%0d exp we=1 d=00000080 stalls=3",
                         o.we, o.res_le, o.stalls);
    end
  endtask

  task automatic test_store_zero_wait;
    obs_t o;
    do_mem(LS_SH, 32'h2002, 32'h0000_ABCD, 5'd4, 32'd0, 0, -1, o);
    checks++;
    if ({o.sel_le, o.sel_be} !== {4'b1100, 4'b0011}) begin
      errors++; $display("FAIL sh_sel got le=%b be=%b exp le=1100 be=0011", o.sel_le, o.sel_be);
    end
    checks++;
    if ({o.req0, o.bus_we, o.wdata, o.baddr} !== {2'b11, 32'hABCD_ABCD, 32'h2000}) begin
      errors++; $display("FAIL sh_bus got req=%b we=%b wd=%h a=%h exp 1 1 abcdabcd 2000",
                         o.req0, o.bus_we, o.wdata, o.baddr);
    end
    checks++;
    if ({o.stall0, o.we} !== 2'b00) begin
      errors++; $display("FAIL sh_nostall got stall=%b we=%b exp 0 0", o.stall0, o.we);
    end
  endtask

  task automatic test_misalign;
    obs_t o;
    do_mem(LS_LW, 32'h3001, 32'd0, 5'd2, 32'h1111_1111, 0, -1, o);
    checks++;
    if ({o.mis0, o.req0, o.we, o.stall0} !== 4'b1000) begin
      errors++; $display("FAIL lw_misalign got mis=%b req=%b we=%b st=%b exp 1 0 0 0",
                         o.mis0, o.req0, o.we, o.stall0);
    end
    do_mem(LS_LH, 32'h3002, 32'd0, 5'd2, 32'hAAAA_5555, 0, -1, o);
    checks++;
    if ({o.mis0, o.req0, o.we, o.res_le} !== {3'b011, 32'hFFFF_AAAA}) begin
      errors++; $display("FAIL lh_aligned got mis=%b req=%b we=%b d=%h exp 0 1 1 ffffaaaa",
                         o.mis0, o.req0, o.we, o.res_le);
    end
  endtask

  task automatic test_llsc;
    obs_t o;
    do_mem(LS_LL, 32'h4000, 32'd0, 5'd5, 32'h0BAD_F00D, 1, -1, o);
    checks++;
    if ({o.we, o.res_le} !== {1'b1, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL ll_data got we=%b d=%h exp 1 0badf00d", o.we, o.res_le);
    end
    do_mem(LS_SC, 32'h4000, 32'h55, 5'd6, 32'd0, 0, -1, o);
    checks++;
    if ({o.req0, o.we, o.res_le, o.reg_o} !== {2'b11, 32'd1, 5'd6}) begin
      errors++; $display("FAIL sc_ok got req=%b we=%b d=%h r=%0d exp 1 1 1 6", o.req0, o.we, o.res_le, o.reg_o);
    end
    do_mem(LS_SC, 32'h4000, 32'h66, 5'd6, 32'd0, 0, -1, o);
    checks++;
    if ({o.req0, o.we, o.res_le, o.stall0} !== {2'b01, 32'd0, 1'b0}) begin
      errors++; $display("FAIL sc_again got req=%b we=%b d=%h st=%b exp 0 1 0 0", o.req0, o.we, o.res_le, o.stall0);
    end
    do_mem(LS_LL, 32'h4000, 32'd0, 5'd5, 32'h1, 0, -1, o);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    do_mem(LS_SC, 32'h4000, 32'h77, 5'd6, 32'd0, 0, -1, o);
    checks++;
    if ({o.req0, o.we, o.res_le} !== {2'b01, 32'd0}) begin
      errors++; $display("FAIL sc_after_flush got req=%b we=%b d=%h exp 0 1 0", o.req0, o.we, o.res_le);
    end
    m_ll = 1'b0;
  endtask

  task automatic test_flush_wait;
    obs_t o;
    do_mem(LS_LW, 32'h4800, 32'd0, 5'd8, 32'hCAFE_0001, 3, 1, o);
    checks++;
    if ({o.we, o.stall_ack, o.stalls} !== {2'b00, 32'd3}) begin
      errors++; $display("FAIL flush_in_wait got we=%b st=%b stalls=%0d exp 0 0 3", o.we, o.stall_ack, o.stalls);
    end
  endtask

  task automatic test_timeout;
    int req_cnt = 0, err_cnt = 0, err_at = -1, stall_bad = 0, err_bad = 0;
    valid = 1'b1; lsop = LS_LW; mem_addr = 32'h5000; w_reg = 5'd1; set_ack(1'b0, 32'd0);
    for (int c = 0; c < 30; c++) begin
      #4;
      if (bus_le.bus_req_o) req_cnt++;
      if (err_le) begin
        err_cnt++;
        if (err_at < 0) err_at = c;
        if (stall_le || we_le) err_bad++;
      end else if (err_at < 0 && !stall_le) begin
        stall_bad++;
      end
      tick;
      if (err_at >= 0) idle_inputs();
    end
    checks++;
    if (req_cnt !== ACK_TO) begin
      errors++; $display("FAIL timeout_req_cycles got %0d exp %0d", req_cnt, ACK_TO);
    end
    checks++;
    if (err_cnt !== 1 || err_at !== ACK_TO) begin
      errors++; $display("FAIL timeout_err_pulse got count=%0d at=%0d exp 1 at %0d", err_cnt, err_at, ACK_TO);
    end
    checks++;
    if (stall_bad !== 0 || err_bad !== 0) begin
      errors++; $display("FAIL timeout_stall got early_drop=%0d stall_or_we_at_err=%0d exp 0 0", stall_bad, err_bad);
    end
  endtask

  task automatic test_rst_in_wait;
    obs_t o;
    valid = 1'b1; lsop = LS_LW; mem_addr = 32'h6000; w_reg = 5'd1; set_ack(1'b0, 32'd0);
    tick; tick;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_le.bus_req_o, stall_le, we_le} !== 3'b000) begin
      errors++; $display("FAIL rst_wait_drop got req=%b st=%b we=%b exp 0 0 0", bus_le.bus_req_o, stall_le, we_le);
    end
    tick;
    rst = 1'b0;
    idle_inputs();
    do_mem(LS_LW, 32'h6004, 32'd0, 5'd11, 32'h7777_0000, 0, -1, o);
    checks++;
    if ({o.stall0, o.we, o.res_le} !== {2'b01, 32'h7777_0000}) begin
      errors++; $display("FAIL rst_wait_idle got st=%b we=%b d=%h exp 0 1 77770000", o.stall0, o.we, o.res_le);
    end
  endtask

  task automatic test_random;
    logic [3:0]  ops [10] = '{LS_LB, LS_LBU, LS_LH, LS_LHU, LS_LW, LS_LL, LS_SB, LS_SH, LS_SW, LS_SC};
    logic [3:0]  op;
    logic [31:0] a, d, rd;
    logic [4:0]  rg;
    int          lat, n;
    bit          mis, ld;
    obs_t        o;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 9)];
      n  = op_bytes(op);
      a  = $urandom;
      if ($urandom_range(0, 4) != 0) a = a & ~32'(n - 1);
      d = $urandom; rd = $urandom; rg = 5'($urandom);
      mis = (int'(a[1:0]) % n) != 0;
      ld  = m_is_load(op);
      lat = mis ? 0 : $urandom_range(0, 4);
      do_mem(op, a, d, rg, rd, lat, -1, o);
      checks++;
      if (mis) begin
        if ({o.mis0, o.req0, o.we, o.stall0} !== 4'b1000) begin
          errors++; $display("FAIL rnd_mis op=%0d a=%h got mis=%b req=%b we=%b exp 1 0 0", op, a, o.mis0, o.req0, o.we);
        end
      end else if (op == LS_SC && !m_ll) begin
        if ({o.req0, o.we, o.res_le, o.res_be} !== {2'b01, 64'd0}) begin
          errors++; $display("FAIL rnd_scfail got req=%b we=%b d=%h exp 0 1 0", o.req0, o.we, o.res_le);
        end
      end else begin
        if ({o.req0, o.mis0, o.bus_we, o.sel_le, o.sel_be, o.baddr, o.stalls, o.we, o.we_b, o.reg_o} !==
            {2'b10, !ld, m_sel(op, a, 1'b0), m_sel(op, a, 1'b1), a & ~32'd3, 32'(lat),
             ld || op == LS_SC, ld || op == LS_SC, rg}) begin
          errors++; $display("FAIL rnd_ctl op=%0d a=%h lat=%0d got sel=%b/%b ba=%h stalls=%0d we=%b exp sel=%b/%b we=%b",
                             op, a, lat, o.sel_le, o.sel_be, o.baddr, o.stalls, o.we,
                             m_sel(op, a, 1'b0), m_sel(op, a, 1'b1), ld || op == LS_SC);
        end
        checks++;
        if (ld) begin
          if ({o.res_le, o.res_be} !== {m_load(op, a, rd, 1'b0), m_load(op, a, rd, 1'b1)}) begin
            errors++; $display("FAIL rnd_load op=%0d a=%h rd=%h got %h/%h exp %h/%h", op, a, rd,
                               o.res_le, o.res_be, m_load(op, a, rd, 1'b0), m_load(op, a, rd, 1'b1));
          end
        end else if (o.wdata !== m_wdata(op, d) || (op == LS_SC && o.res_le !== 32'd1)) begin
          errors++; $display("FAIL rnd_store op=%0d got wd=%h res=%h exp wd=%h", op, o.wdata, o.res_le, m_wdata(op, d));
        end
        if (op == LS_LL) m_ll = 1'b1;
        if (op == LS_SC) m_ll = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_addr = '0; w_data = '0; w_reg = '0;
    idle_inputs();
    test_reset();
    test_passthrough();
    test_load_wait();
    test_store_zero_wait();
    test_misalign();
    test_llsc();
    test_flush_wait();
    test_timeout();
    test_rst_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Second-generation MEM pipeline stage, between the EX/MEM and MEM/WB pipeline registers. For ALU results it passes the write-back triple through unchanged. It also executes loads and stores (byte, half, word, LL/SC) over a request/acknowledge data bus and requests a pipeline stall while the bus is busy. It adds the following beyond a plain pass-through stage:
- misalignment detection;
- endian-selectable byte lanes;
- bus timeout;
- an LL/SC link bit.

Parameters:
ADDR_W, 32, data-bus address width (bits).
REG_ADDR_W, 5, register-file address width.
BIG_ENDIAN, 0, 0 = little-endian byte lanes, 1 = big-endian.
ACK_TIMEOUT, 15, maximum cycles spent in WAIT before a bus error (≥1).

Ports:
clk  in  1  clock.
rst  in  1  reset. Synchronous, active-high.
valid_i  in  1  EX/MEM content is a live instruction.
lsop_i  in  4  load/store opcode (package constants).
w_reg_addr_i  in  REG_ADDR_W  destination register.
we_i  in  1  register write enable for ALU ops.
w_data_i  in  32  ALU result, or store data for store ops.
mem_addr_i  in  ADDR_W  effective address.
flush_i  in  1  pipeline flush (exception/eret).
w_reg_addr_o  out  REG_ADDR_W  to MEM/WB.
we_o  out  1  to MEM/WB.
w_data_o  out  32  to MEM/WB.
stall_req_o  out  1  stall request to pipeline control.
misalign_o  out  1  address-error exception request.
bus_err_o  out  1  bus timeout exception request (one-cycle pulse).
bus_req_o  out  1  bus request.
bus_we_o  out  1  bus write.
bus_addr_o  out  ADDR_W  word-aligned address: mem_addr low 2 bits forced to 0.
bus_sel_o  out  4  byte-lane enables.
bus_wdata_o  out  32  write data, replicated across lanes.
bus_rdata_i  in  32  read data.
bus_ack_i  in  1  bus completes the transfer this cycle.

Behaviour:
- Outputs are combinational from inputs and state, with registered state: fsm, llbit, tcnt, flushed, plus latched op/addr/data/reg.
- While rst=1, every output is 0. On the clock edge with rst=1: fsm:=IDLE, llbit:=0, tcnt:=0, flushed:=0.
- rst mid-WAIT abandons the transfer. bus_req_o drops in the same cycle.
- Opcode classes: LS_NONE, LB, LBU, LH, LHU, LW, LL, SB, SH, SW, SC.
- LS_NONE or valid_i=0:
  - outputs = inputs (we_o = we_i & valid_i);
  - no bus activity; no stall.
- Misalignment check:
  - half ops fault when addr[0]=1; word/LL/SC fault when addr[1:0]≠0;
  - on a fault: misalign_o=1, we_o=0, bus_req_o=0, stall_req_o=0, fsm stays IDLE.
- Lane selection:
  - b = addr[1:0], h = addr[1];
  - if BIG_ENDIAN=1, b ^= 2'b11 and h ^= 1.
- Store lanes:
  - SB: sel = 1<<b, wdata = {4{data[7:0]}};
  - SH: sel = 2'b11<<(2h), wdata = {2{data[15:0]}};
  - SW/SC: sel = 4'hF.
  - Stores keep we_o=0 except SC (see below).
- Loads: sel follows the same pattern as stores. On ack, the selected byte/half is extracted; LB/LH sign-extend, LBU/LHU zero-extend, LW/LL take the full word. we_o=1 in the ack cycle.
- FSM:
  - IDLE with a valid aligned memory op: bus_req_o=1 from the live inputs.
  - If bus_ack_i=1 in that cycle: complete, zero-wait, no stall.
  - Otherwise stall_req_o=1, latch op/addr/data/reg, tcnt:=1, and go to WAIT.
  - WAIT: bus_req_o=1 driven from the latched fields; stall_req_o=1 until completion.
  - On ack: the result is presented, stall_req_o=0, return to IDLE.
  - When tcnt=ACK_TIMEOUT without ack: bus_req_o=0, bus_err_o=1, we_o=0, stall_req_o=0, return to IDLE. Otherwise tcnt increments.
  - An ack arriving in the same cycle as the timeout takes priority: normal completion.
- LL: on ack, llbit:=1.
- SC with llbit=0:
  - no bus access; w_data_o=0, we_o=1, completes in a single cycle.
- SC with llbit=1:
  - store proceeds; on ack, w_data_o=1, we_o=1, llbit:=0.
- flush_i:
  - clears llbit, with priority over a same-cycle LL set;
  - in IDLE, suppresses the op (treated as valid_i=0);
  - in WAIT, sets flushed. The transfer still runs to ack/timeout, but we_o=0 and bus_err_o=0 on completion. flushed clears on return to IDLE.

Decomposition:
- Package lsu_pkg holds:
  - LS_* opcode localparams (4-bit);
  - FSM state encoding (IDLE, WAIT);
  - function for lane/byte-enable generation;
  - function for load extraction/extension.
- One sub-module, lsu_align: purely combinational lane select, store replication, load formatting and misalignment check, parametrised by BIG_ENDIAN. mem_lsu holds the FSM, latches, timeout counter and llbit.

Test Plan:
- ALU pass-through: lsop=NONE, reg=5'd3, we=1, data=32'hDEADBEEF → outputs identical in the same cycle, stall=0, bus_req=0.
- LB at 0x1003, little-endian, rdata=32'h80FF_1234, ack after 3 cycles → stall high for 3 cycles, sel=4'b1000, w_data_o=32'hFFFF_FF80, we_o=1 in the ack cycle. Repeat with LBU → 32'h0000_0080.
- SH at 0x2002, data=32'h0000_ABCD, zero-wait ack → sel=4'b1100, wdata=32'hABCD_ABCD, stall never asserted. With BIG_ENDIAN=1 → sel=4'b0011.
- LW at 0x3001 → misalign_o=1, bus_req_o=0, we_o=0, no stall.
- LL then SC, both to 0x4000 → SC writes w_data_o=1. Second SC → no bus request, w_data_o=0, we_o=1. LL, then flush, then SC → w_data_o=0.
- No ack, ACK_TIMEOUT=15 → bus_req held for 15 cycles, then bus_err_o pulses once and stall drops. Assert rst in WAIT → bus_req_o=0 in the same cycle, then fsm=IDLE.
